// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream MSB-first into DATA_W-bit words,
// writes them at consecutive word addresses and holds the core while loading.
module imem_loader #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_length,
   input  logic [7:0]        i_byte_in,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_cpu_hold,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StWrite,
      StDone
   } state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic [BCW-1:0]    r_byte_cnt;
   logic [ADDR_W:0]   r_word_cnt;
   logic [ADDR_W:0]   r_length;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_word;
   logic              r_byte_ready;
   logic              r_busy;
   logic              r_cpu_hold;
   logic              r_done;

   logic              w_accept;
   logic              w_last_byte;
   logic [ADDR_W:0]   w_word_cnt_inc;
   logic              w_last_word;

   // r_byte_ready is a pure function of state, so acceptance never loops back into ready.
   assign w_accept       = r_byte_ready & i_byte_valid;
   assign w_last_byte    = (r_byte_cnt == BCW'(NBYTES - 1));
   assign w_word_cnt_inc = r_word_cnt + (ADDR_W + 1)'(1);
   assign w_last_word    = (w_word_cnt_inc == r_length);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_next = (i_length != '0) ? StRecv : StDone;
            end
         end
         StRecv: begin
            if (w_accept && w_last_byte) begin
               w_state_next = StWrite;
            end
         end
         StWrite: begin
            w_state_next = w_last_word ? StDone : StRecv;
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_byte_cnt   <= '0;
         r_word_cnt   <= '0;
         r_length     <= '0;
         r_addr       <= '0;
         r_word       <= '0;
         r_byte_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         // Status outputs are registered from the next state so they align with r_state.
         r_byte_ready <= (w_state_next == StRecv);
         r_busy       <= (w_state_next != StIdle);
         r_cpu_hold   <= (w_state_next != StIdle);
         r_done       <= (w_state_next == StDone);

         if ((r_state == StIdle) && i_start) begin
            r_addr     <= i_base_addr;
            r_length   <= i_length;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
         end

         if (w_accept) begin
            r_word     <= {r_word[DATA_W-9:0], i_byte_in};
            r_byte_cnt <= w_last_byte ? '0 : (r_byte_cnt + BCW'(1));
         end

         if (r_state == StWrite) begin
            r_addr     <= r_addr + ADDR_W'(1);
            r_word_cnt <= w_word_cnt_inc;
         end
      end
   end

   assign o_mem_we     = (r_state == StWrite);
   assign o_mem_waddr  = o_mem_we ? r_addr : '0;
   assign o_mem_wdata  = o_mem_we ? r_word : '0;
   assign o_byte_ready = r_byte_ready;
   assign o_busy       = r_busy;
   assign o_cpu_hold   = r_cpu_hold;
   assign o_done       = r_done;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the fetch stage's instruction-memory read port.
- Accepts a byte stream from a host/debug link and assembles 24-bit instructions MSB-first.
- Writes each assembled instruction into instruction memory at consecutive word addresses.
- Holds the core (cpu_hold) while a load is in progress, so fetch never reads a partially loaded program.

Parameters:
- DATA_W, 24, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W).
- NBYTES, DATA_W/8 = 3, bytes per instruction (derived, not overridden).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load (sampled only in IDLE).
- base_addr  in  ADDR_W  first word address, captured on an accepted start.
- length  in  ADDR_W+1  number of words to load, captured on an accepted start (0..2^ADDR_W).
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  core must stall/hold the PC while high.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; all outputs 0; byte counter, word counter, address register and assembly register cleared.
  - Reset mid-load discards the partial word; no write is issued for it.
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready. The sender holds byte_in/byte_valid until it is accepted. byte_ready never depends combinationally on byte_valid.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0, busy=0, cpu_hold=0.
  - start=1 captures base_addr and length.
  - Next state is RECV if length!=0, otherwise DONE.
- RECV:
  - byte_ready=1, busy=1, cpu_hold=1.
  - Each accepted byte shifts into the assembly register MSB-first: word = {word[DATA_W-9:0], byte_in}.
  - Byte counter runs 0..NBYTES-1. On acceptance of byte NBYTES-1, the counter returns to 0 and the next state is WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_waddr=current address, mem_wdata=assembled word; byte_ready=0.
  - The address increments modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0 is legal and silent).
  - The word counter increments. If it equals length, next state is DONE; otherwise RECV.
- DONE (one cycle): done=1, busy=1, cpu_hold=1; next state is IDLE. cpu_hold falls on the edge that enters IDLE.
- Latency:
  - Accepted start to first byte_ready=1: 1 cycle.
  - Third byte accepted to mem_we: 1 cycle.
  - Minimum per word: NBYTES+1 cycles.
  - Last write to done: 1 cycle.
- start while not in IDLE is ignored; no restart and no re-capture.
- byte_valid in IDLE/WRITE/DONE is not accepted; the data stays pending at the sender.
- length=0: no writes; done pulses the cycle after start.
- length=2^ADDR_W: fills the whole memory, ending with the address wrapped back to base_addr.
- Outputs are registered except mem_we/mem_waddr/mem_wdata, which are state-decoded from registers (glitch-free, no input-to-output combinational path).

Test Plan:
- Reset mid-load: assert reset after 2 of 3 bytes -> all outputs 0 immediately (asynchronous). After release and a new load of 1 word 0x0000AA, memory gets 0x0000AA, not mixed with stale bytes.
- Basic load: start, base_addr=0, length=2; bytes 00 00 01 00 00 02 back-to-back -> mem_we pulses writing addr0=0x000001, then addr1=0x000002. done 1 cycle after the second write. cpu_hold high from the cycle after start through done. A fetch stage then reads 1, 2 from PC 0, 1.
- Sender stalls: same load with byte_valid toggling 1,0,0,1,... -> identical writes. mem_we only after the third accepted byte. No byte is dropped or duplicated.
- Wrap-around: base_addr=0xFF, length=2; words 0xABCDEF, 0x123456 -> writes addr 0xFF=0xABCDEF, then addr 0x00=0x123456.
- length=0 and start while busy:
  - start with length=0 -> done the next cycle, no mem_we.
  - start pulsed mid-load with base_addr=0x40 -> ignored; writes continue at the original addresses.
